sata_tx_scheduler: RTL and testbench

Schedules the 32-bit DWORD stream that feeds the Altera SATA TX adapter. It inserts the mandatory ALIGN primitive pairs every ALIGN_INTERVAL DWORDs, fills idle slots with SYNC, and applies valid/ready backpressure to the link layer. Each output DWORD is held for the full per-generation slot period (4/2/1 cycles for Gen1/2/3), so the adapter's free-running sampling phase never drops or duplicates a DWORD. It sits between the link layer and sata_tx_adapter in the tx_clkout domain.

---
 rtl/sata_tx_pkg.sv | 31 +++
 rtl/sata_tx_slot_timer.sv | 37 +++
 rtl/sata_tx_scheduler.sv | 101 ++++++++++
 tb/tb_sata_tx_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_tx_pkg.sv
// Shared constants, gen encodings, slot-period helper and FSM state type
// for the SATA TX DWORD scheduler.
package sata_tx_pkg;

   localparam logic [31:0] ALIGN_DATA = 32'h7B4A_4ABC;
   localparam logic [3:0]  ALIGN_CTRL = 4'b0001;
   localparam logic [31:0] SYNC_DATA  = 32'hB5B5_957C;
   localparam logic [3:0]  SYNC_CTRL  = 4'b0001;

   localparam logic [1:0] GEN1 = 2'b00;
   localparam logic [1:0] GEN2 = 2'b01;
   localparam logic [1:0] GEN3 = 2'b10;

   typedef enum logic {
      S_ALIGN = 1'b0,
      S_DATA  = 1'b1
   } state_t;

   // Cycles per DWORD slot; any gen with bit 1 set is Gen3.
   function automatic logic [2:0] gen_period(input logic [1:0] gen);
      if ((gen & GEN3) != 2'b00)
         return 3'd1;
      else if (gen == GEN1)
         return 3'd4;
      else if (gen == GEN2)
         return 3'd2;
      else
         return 3'd2;
   endfunction

endpackage

// File: rtl/sata_tx_slot_timer.sv
// Slot timer: registers sata_gen and down-counts each DWORD slot, flagging
// the last cycle (reload point) and the first cycle of every slot.
module sata_tx_slot_timer
   import sata_tx_pkg::*;
(
   input  logic       tx_clkout,
   input  logic       tx_reset,
   input  logic [1:0] sata_gen,
   output logic       slot_last,
   output logic       slot_first
);

   logic [1:0] gen_q;
   logic [1:0] cnt;

   // Left free-running through reset so the first slot after release
   // already uses the gen presented while reset was held.
   always_ff @(posedge tx_clkout) begin
      gen_q <= sata_gen;
   end

   assign slot_last = (cnt == 2'd0);

   always_ff @(posedge tx_clkout) begin
      if (tx_reset) begin
         cnt        <= '0;
         slot_first <= 1'b0;
      end else begin
         slot_first <= slot_last;
         if (slot_last)
            cnt <= 2'(gen_period(gen_q) - 3'd1);
         else
            cnt <= cnt - 2'd1;
      end
   end

endmodule

// File: rtl/sata_tx_scheduler.sv
// DWORD scheduler ahead of the SATA TX adapter: periodic ALIGN bursts,
// SYNC fill, link backpressure, and per-gen slot hold of every output DWORD.
module sata_tx_scheduler
   import sata_tx_pkg::*;
#(
   parameter int unsigned ALIGN_INTERVAL = 256,
   parameter int unsigned ALIGN_COUNT    = 2
)
(
   input  logic        tx_clkout,
   input  logic        tx_reset,
   input  logic [1:0]  sata_gen,
   input  logic        phy_ready,
   input  logic        align_req,
   input  logic [31:0] link_data,
   input  logic [3:0]  link_ctrl,
   input  logic        link_valid,
   output logic        link_ready,
   output logic [31:0] tx_data,
   output logic [3:0]  tx_ctrl,
   output logic        dword_strobe,
   output logic        align_active
);

   localparam int unsigned DW_W = (ALIGN_INTERVAL > 1) ? $clog2(ALIGN_INTERVAL) : 1;
   localparam int unsigned AC_W = $clog2(ALIGN_COUNT + 1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(ALIGN_INTERVAL - 1);
   localparam logic [AC_W-1:0] AC_LAST = AC_W'(ALIGN_COUNT - 1);

   logic            slot_last;
   logic            slot_first;
   state_t          state;
   logic [AC_W-1:0] align_cnt;
   logic [DW_W-1:0] dw_cnt;
   logic            align_pend;
   logic            take;

   sata_tx_slot_timer u_slot_timer (
      .tx_clkout  (tx_clkout),
      .tx_reset   (tx_reset),
      .sata_gen   (sata_gen),
      .slot_last  (slot_last),
      .slot_first (slot_first)
   );

   // state names the kind of slot loaded at the next slot_last edge.
   assign link_ready   = slot_last & phy_ready & ~align_pend & (state == S_DATA);
   assign take         = link_valid & link_ready;
   assign dword_strobe = slot_first;

   always_ff @(posedge tx_clkout) begin
      if (tx_reset) begin
         state        <= S_ALIGN;
         align_cnt    <= '0;
         dw_cnt       <= '0;
         align_pend   <= 1'b0;
         tx_data      <= ALIGN_DATA;
         tx_ctrl      <= ALIGN_CTRL;
         align_active <= 1'b1;
      end else begin
         // Requests while a burst is queued or on the wire merge into it.
         if (align_req && (state == S_DATA) && !align_active)
            align_pend <= 1'b1;
         if (slot_last) begin
            if (!phy_ready) begin
               tx_data      <= ALIGN_DATA;
               tx_ctrl      <= ALIGN_CTRL;
               align_active <= 1'b1;
               state        <= S_ALIGN;
               align_cnt    <= '0;
               dw_cnt       <= '0;
            end else if (state == S_ALIGN) begin
               tx_data      <= ALIGN_DATA;
               tx_ctrl      <= ALIGN_CTRL;
               align_active <= 1'b1;
               align_cnt    <= align_cnt + AC_W'(1);
               if (align_cnt == AC_LAST) begin
                  state      <= S_DATA;
                  dw_cnt     <= '0;
                  align_pend <= 1'b0;
               end
            end else begin
               if (take) begin
                  tx_data <= link_data;
                  tx_ctrl <= link_ctrl;
               end else begin
                  tx_data <= SYNC_DATA;
                  tx_ctrl <= SYNC_CTRL;
               end
               align_active <= 1'b0;
               dw_cnt       <= dw_cnt + DW_W'(1);
               if ((dw_cnt == DW_LAST) || align_pend) begin
                  state     <= S_ALIGN;
                  align_cnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sata_tx_scheduler.sv
// Directed bench for sata_tx_scheduler: per-slot expectation tables with
// per-cycle checks of data, ctrl, ALIGN flag, strobe and link_ready.
module tb_sata_tx_scheduler;

   localparam logic [35:0] EXP_ALIGN = {4'b0001, 32'h7B4A_4ABC};
   localparam logic [35:0] EXP_SYNC  = {4'b0001, 32'hB5B5_957C};

   localparam int K_A   = 0;  // ALIGN slot
   localparam int K_SNR = 1;  // SYNC slot, link_ready low before it
   localparam int K_S   = 2;  // SYNC slot, link_ready high before it (no valid)
   localparam int K_W   = 3;  // link word slot

   localparam int A_NONE = 0;
   localparam int A_GEN1 = 1;
   localparam int A_GEN3 = 2;
   localparam int A_REQ  = 3;
   localparam int A_PHY0 = 4;
   localparam int A_PHY1 = 5;
   localparam int A_RST  = 6;

   typedef struct {
      int kind;
      int n;
      int act_c;
      int act;
   } slot_t;

   logic        tx_clkout = 1'b0;
   logic        tx_reset;
   logic [1:0]  sata_gen;
   logic        phy_ready;
   logic        align_req;
   logic [31:0] link_data;
   logic [3:0]  link_ctrl;
   logic        link_valid;
   logic        link_ready;
   logic [31:0] tx_data;
   logic [3:0]  tx_ctrl;
   logic        dword_strobe;
   logic        align_active;

   int unsigned n_asserts = 0;
   int unsigned n_fails   = 0;
   int unsigned src_idx   = 0;
   int unsigned exp_word  = 0;
   int unsigned cyc       = 0;
   slot_t       q[$];

   always #5 tx_clkout = ~tx_clkout;

   sata_tx_scheduler #(
      .ALIGN_INTERVAL (256),
      .ALIGN_COUNT    (2)
   ) dut (
      .tx_clkout    (tx_clkout),
      .tx_reset     (tx_reset),
      .sata_gen     (sata_gen),
      .phy_ready    (phy_ready),
      .align_req    (align_req),
      .link_data    (link_data),
      .link_ctrl    (link_ctrl),
      .link_valid   (link_valid),
      .link_ready   (link_ready),
      .tx_data      (tx_data),
      .tx_ctrl      (tx_ctrl),
      .dword_strobe (dword_strobe),
      .align_active (align_active)
   );

   function automatic logic [35:0] wexp(input int unsigned i);
      logic [31:0] iv;
      iv = i;
      return {iv[3:0], 32'hD000_0000 + iv};
   endfunction

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      logic acc;
      @(negedge tx_clkout);
      acc = link_valid & link_ready;
      @(posedge tx_clkout);
      #1;
      cyc++;
      if (acc) begin
         src_idx++;
         {link_ctrl, link_data} = wexp(src_idx);
      end
   endtask

   task automatic push(input int kind, input int n, input int count);
      for (int i = 0; i < count; i++)
         q.push_back('{kind: kind, n: n, act_c: -1, act: A_NONE});
   endtask

   task automatic set_act(input int idx, input int c, input int a);
      slot_t s;
      s = q[idx];
      s.act_c = c;
      s.act = a;
      q[idx] = s;
   endtask

   task automatic do_act(input int a);
      case (a)
         A_GEN1: sata_gen = 2'b00;
         A_GEN3: sata_gen = 2'b10;
         A_REQ:  align_req = 1'b1;
         A_PHY0: phy_ready = 1'b0;
         A_PHY1: phy_ready = 1'b1;
         A_RST:  tx_reset = 1'b1;
         default: ;
      endcase
   endtask

   task automatic chk_slot(input string tag, input int kind);
      logic [35:0] e;
      if (kind == K_A)
         e = EXP_ALIGN;
      else if (kind == K_W)
         e = wexp(exp_word);
      else
         e = EXP_SYNC;
      chk({tag, "_dword"}, {tx_ctrl, tx_data}, e);
      chk({tag, "_align"}, 36'(align_active), 36'(kind == K_A));
   endtask

   task automatic run_slots(input string tag);
      for (int k = 0; k < q.size(); k++) begin
         for (int c = 0; c < q[k].n; c++) begin
            step();
            align_req = 1'b0;
            if (q[k].act_c == c)
               do_act(q[k].act);
            #1;
            chk({tag, "_strobe"}, 36'(dword_strobe), 36'(c == 0));
            chk_slot(tag, q[k].kind);
            if (k + 1 < q.size())
               chk({tag, "_ready"}, 36'(link_ready),
                   36'((c == q[k].n - 1) && (q[k+1].kind >= K_S)));
         end
         if (q[k].kind == K_W)
            exp_word++;
      end
      q.delete();
   endtask

   task automatic do_reset(input string tag, input logic [1:0] gen, input logic valid);
      tx_reset   = 1'b1;
      sata_gen   = gen;
      link_valid = valid;
      phy_ready  = 1'b1;
      align_req  = 1'b0;
      step();
      step();
      src_idx  = 0;
      exp_word = 0;
      {link_ctrl, link_data} = wexp(0);
      chk({tag, "_rst_dword"}, {tx_ctrl, tx_data}, EXP_ALIGN);
      chk({tag, "_rst_align"}, 36'(align_active), 36'(1));
      chk({tag, "_rst_strobe"}, 36'(dword_strobe), 36'(0));
      chk({tag, "_rst_ready"}, 36'(link_ready), 36'(0));
      tx_reset = 1'b0;
      #1;
      chk({tag, "_rel_ready"}, 36'(link_ready), 36'(0));
   endtask

   initial begin
      tx_reset   = 1'b1;
      sata_gen   = 2'b10;
      phy_ready  = 1'b1;
      align_req  = 1'b0;
      link_valid = 1'b0;
      {link_ctrl, link_data} = wexp(0);

      // Gen3 streaming: 2 ALIGN, 256 words, repeating, no gaps or duplicates.
      do_reset("g3", 2'b10, 1'b1);
      push(K_A, 1, 2);
      push(K_W, 1, 256);
      push(K_A, 1, 2);
      push(K_W, 1, 256);
      push(K_A, 1, 2);
      push(K_W, 1, 3);
      run_slots("g3");

      // Gen1 idle: SYNC held 4 cycles, ALIGN pair every 258 slots.
      do_reset("g1", 2'b00, 1'b0);
      push(K_A, 4, 2);
      push(K_S, 4, 256);
      push(K_A, 4, 2);
      push(K_S, 4, 2);
      run_slots("g1");

      // Gen2 -> Gen1 -> Gen3 mid-slot; slot lengths switch at reload only.
      do_reset("gsw", 2'b01, 1'b0);
      push(K_A, 2, 2);
      set_act(1, 0, A_GEN1);
      push(K_S, 4, 1);
      set_act(2, 1, A_GEN3);
      push(K_S, 1, 255);
      push(K_A, 1, 2);
      push(K_S, 1, 2);
      run_slots("gsw");

      // align_req at dw_cnt 100, repeated inside the resulting burst.
      do_reset("req", 2'b10, 1'b1);
      push(K_A, 1, 2);
      push(K_W, 1, 101);
      set_act(101, 0, A_REQ);
      push(K_SNR, 1, 1);
      push(K_A, 1, 2);
      set_act(104, 0, A_REQ);
      set_act(105, 0, A_REQ);
      push(K_W, 1, 256);
      push(K_A, 1, 2);
      push(K_W, 1, 2);
      run_slots("req");

      // phy_ready low for 10 slots mid-data; held word resumes after a full burst.
      do_reset("phy", 2'b10, 1'b1);
      push(K_A, 1, 2);
      push(K_W, 1, 48);
      set_act(49, 0, A_PHY0);
      push(K_A, 1, 10);
      set_act(59, 0, A_PHY1);
      push(K_A, 1, 2);
      push(K_W, 1, 4);
      run_slots("phy");

      // Reset in the last cycle of the second Gen1 ALIGN slot.
      do_reset("rmid", 2'b00, 1'b0);
      push(K_A, 4, 2);
      set_act(1, 3, A_RST);
      run_slots("rmid");
      step();
      chk("rmid_abort_dword", {tx_ctrl, tx_data}, EXP_ALIGN);
      chk("rmid_abort_strobe", 36'(dword_strobe), 36'(0));
      chk("rmid_abort_align", 36'(align_active), 36'(1));
      chk("rmid_abort_ready", 36'(link_ready), 36'(0));
      do_reset("rnew", 2'b00, 1'b0);
      push(K_A, 4, 2);
      push(K_S, 4, 3);
      run_slots("rnew");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
